// File: rtl/dispatch_lane_splitter_if.sv
// dispatch_lane_splitter_if: per-slot dispatch streams in, lane-wide packets out (slave = splitter, master = producer/consumer side)
interface dispatch_lane_splitter_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 4,
  parameter int XLEN        = 32,
  parameter int HDRW        = 96
);
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int ISW_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam int PID_W = NUM_PACKETS > 1 ? $clog2(NUM_PACKETS) : 1;
  logic [NUM_INPUTS-1:0]                  in_valid;
  logic [NUM_INPUTS-1:0]                  in_ready;
  logic [NUM_INPUTS*HDRW-1:0]             in_hdr;
  logic [NUM_INPUTS*NUM_THREADS-1:0]      in_tmask;
  logic [NUM_INPUTS*3*NUM_THREADS*XLEN-1:0] in_data;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [HDRW-1:0]                        out_hdr;
  logic [NUM_LANES-1:0]                   out_tmask;
  logic [3*NUM_LANES*XLEN-1:0]            out_data;
  logic [PID_W-1:0]                       out_pid;
  logic                                   out_sop;
  logic                                   out_eop;
  logic [ISW_W-1:0]                       out_isw;
  modport slave (
    input  in_valid, in_hdr, in_tmask, in_data, out_ready,
    output in_ready, out_valid, out_hdr, out_tmask, out_data, out_pid, out_sop, out_eop, out_isw
  );
  modport master (
    output in_valid, in_hdr, in_tmask, in_data, out_ready,
    input  in_ready, out_valid, out_hdr, out_tmask, out_data, out_pid, out_sop, out_eop, out_isw
  );
endinterface

// File: rtl/dispatch_lane_splitter.sv
// dispatch_lane_splitter: round-robin picks a dispatch slot and slices its request into lane-wide packets (ports: clk, reset, bus slave)
module dispatch_lane_splitter #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 4,
  parameter int XLEN        = 32,
  parameter int HDRW        = 96
) (
  input logic clk,
  input logic reset,
  dispatch_lane_splitter_if.slave bus
);
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int ISW_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam int PID_W = NUM_PACKETS > 1 ? $clog2(NUM_PACKETS) : 1;
  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state;
  logic locked, arb_found, first_found, eop, xfer;
  logic [ISW_W-1:0] lock_isw, rr_ptr, arb_isw, grant;
  logic [PID_W-1:0] cur_pid, first_pid, next_pid, pid;
  logic [NUM_PACKETS-1:0] nz;
  logic [NUM_THREADS-1:0] tmask;
  assign locked = state == SPLIT;
  always_comb begin
    arb_isw = '0;
    arb_found = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (!arb_found && bus.in_valid[(int'(rr_ptr) + i) % NUM_INPUTS]) begin
        arb_found = 1'b1;
        arb_isw = ISW_W'((int'(rr_ptr) + i) % NUM_INPUTS);
      end
    grant = locked ? lock_isw : arb_isw;
    tmask = bus.in_tmask[grant*NUM_THREADS +: NUM_THREADS];
    for (int p = 0; p < NUM_PACKETS; p++) nz[p] = |tmask[p*NUM_LANES +: NUM_LANES];
    first_pid = '0;
    first_found = 1'b0;
    for (int p = 0; p < NUM_PACKETS; p++)
      if (!first_found && nz[p]) begin
        first_found = 1'b1;
        first_pid = PID_W'(p);
      end
    pid = locked ? cur_pid : first_pid;
    // eop stays high until a later non-empty packet is found, which is also the next pid
    eop = 1'b1;
    next_pid = '0;
    for (int p = 0; p < NUM_PACKETS; p++)
      if (eop && p > int'(pid) && nz[p]) begin
        eop = 1'b0;
        next_pid = PID_W'(p);
      end
  end
  assign bus.out_valid = ~reset & (locked | (|bus.in_valid));
  assign xfer = bus.out_valid & bus.out_ready;
  assign bus.in_ready = (xfer & eop) ? NUM_INPUTS'(1) << grant : '0;
  assign bus.out_hdr = bus.in_hdr[grant*HDRW +: HDRW];
  assign bus.out_tmask = tmask[pid*NUM_LANES +: NUM_LANES];
  assign bus.out_pid = pid;
  assign bus.out_sop = ~locked;
  assign bus.out_eop = eop;
  assign bus.out_isw = grant;
  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < NUM_LANES; l++)
        bus.out_data[(k*NUM_LANES + l)*XLEN +: XLEN] =
          bus.in_data[grant*3*NUM_THREADS*XLEN + (k*NUM_THREADS + int'(pid)*NUM_LANES + l)*XLEN +: XLEN];
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      lock_isw <= '0;
      cur_pid <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      if (eop) begin
        state <= IDLE;
        rr_ptr <= (grant == ISW_W'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
      end else begin
        state <= SPLIT;
        lock_isw <= grant;
        cur_pid <= next_pid;
      end
    end
endmodule

// File: tb/tb_dispatch_lane_splitter.sv
// tb_dispatch_lane_splitter: random dispatch traffic checked against a packet-list reference model
module tb_dispatch_lane_splitter;
  localparam int NI = 4, NT = 8, NL = 4, XLEN = 32, HDRW = 96, NP = NT / NL;
  logic clk = 1'b0;
  logic reset;
  int checks = 0, errors = 0;
  logic [XLEN-1:0] opd [NI][3][NT];
  logic [NT-1:0] tm [NI];
  logic [HDRW-1:0] hd [NI];
  bit vld [NI];
  int act, idx, rr, g, n, pid;
  int lst [NP];
  bit eop;
  logic [3*NL*XLEN-1:0] ed;
  dispatch_lane_splitter_if #(.NUM_INPUTS(NI), .NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XLEN), .HDRW(HDRW)) bus ();
  dispatch_lane_splitter #(.NUM_INPUTS(NI), .NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XLEN), .HDRW(HDRW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  for (genvar i = 0; i < NI; i++) begin : g_hold
    assert property (@(posedge clk) disable iff (reset) bus.in_valid[i] && !bus.in_ready[i] |=> bus.in_valid[i])
      else $error("FAIL hold slot %0d dropped valid before in_ready", i);
  end
  task automatic check(input string tag, input logic [3*NL*XLEN-1:0] got, input logic [3*NL*XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic new_req(input int s);
    int c;
    c = $urandom_range(0, 5);
    tm[s] = c == 0 ? 8'h00 : c == 1 ? 8'hFF : c == 2 ? 8'hF0 : c == 3 ? 8'h0F : 8'($urandom);
    hd[s] = {$urandom, $urandom, $urandom};
    for (int k = 0; k < 3; k++)
      for (int t = 0; t < NT; t++) opd[s][k][t] = $urandom;
    vld[s] = 1'b1;
  endtask
  task automatic drive();
    for (int s = 0; s < NI; s++) begin
      bus.in_valid[s] = vld[s];
      bus.in_hdr[s*HDRW +: HDRW] = hd[s];
      bus.in_tmask[s*NT +: NT] = tm[s];
      for (int k = 0; k < 3; k++)
        for (int t = 0; t < NT; t++) bus.in_data[(s*3*NT + k*NT + t)*XLEN +: XLEN] = opd[s][k][t];
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    for (int s = 0; s < NI; s++) begin
      vld[s] = 1'b0;
      tm[s] = '0;
      hd[s] = '0;
      for (int k = 0; k < 3; k++)
        for (int t = 0; t < NT; t++) opd[s][k][t] = '0;
    end
    new_req(0);
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 0);
    act = -1;
    idx = 0;
    rr = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      for (int s = 0; s < NI; s++) if (!vld[s] && $urandom_range(0, 2) == 0) new_req(s);
      bus.out_ready = $urandom_range(0, 3) != 0;
      drive();
      #1;
      if (reset) begin
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        act = -1;
        idx = 0;
        rr = 0;
      end else begin
        g = act;
        if (g < 0)
          for (int i = 0; i < NI; i++) if (g < 0 && vld[(rr + i) % NI]) g = (rr + i) % NI;
        check("out_valid", bus.out_valid, g >= 0);
        if (g < 0) check("idle_in_ready", bus.in_ready, 0);
        else begin
          n = 0;
          for (int p = 0; p < NP; p++) if (tm[g][p*NL +: NL] != 0) begin lst[n] = p; n++; end
          if (n == 0) begin lst[0] = 0; n = 1; end
          pid = lst[idx];
          eop = idx == n - 1;
          for (int k = 0; k < 3; k++)
            for (int l = 0; l < NL; l++) ed[(k*NL + l)*XLEN +: XLEN] = opd[g][k][pid*NL + l];
          check("isw", bus.out_isw, g);
          check("pid", bus.out_pid, pid);
          check("sop", bus.out_sop, idx == 0);
          check("eop", bus.out_eop, eop);
          check("tmask", bus.out_tmask, tm[g][pid*NL +: NL]);
          check("hdr", bus.out_hdr, hd[g]);
          check("data", bus.out_data, ed);
          check("in_ready", bus.in_ready, (bus.out_ready && eop) ? (4'b1 << g) : 4'b0);
          if (bus.out_ready) begin
            if (eop) begin
              vld[g] = 1'b0;
              act = -1;
              idx = 0;
              rr = (g + 1) % NI;
            end else begin
              act = g;
              idx++;
            end
          end
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
